// File: rtl/rfarb_pkg.sv
// Shared constants for the register-file write arbiter: default widths, grant encoding, x0 index.
package rfarb_pkg;
  localparam int ADDR_W_DEF = 6;
  localparam int DATA_W_DEF = 32;

  localparam logic GRANT_REQ0 = 1'b0;
  localparam logic GRANT_REQ1 = 1'b1;

  localparam int REG_X0 = 0;
endpackage

// File: rtl/rfarb_fifo.sv
// Per-requester writeback FIFO with head outputs and a per-slot valid/reg view for hazard matching.
// Latency: pushed entry visible at head the cycle after push; push ignored when full, pop ignored when empty.
module rfarb_fifo #(
  parameter int DEPTH = 2,
  parameter int AW    = 6,
  parameter int DW    = 32
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      push,
  input  logic [AW-1:0]             push_reg,
  input  logic [DW-1:0]             push_dat,
  input  logic                      pop,
  output logic                      full,
  output logic                      empty,
  output logic [AW-1:0]             head_reg,
  output logic [DW-1:0]             head_dat,
  output logic [DEPTH-1:0]          ent_vld,
  output logic [DEPTH-1:0][AW-1:0]  ent_reg
);
  localparam int PW = $clog2(DEPTH);

  logic [PW-1:0]            wr_ptr;
  logic [PW-1:0]            rd_ptr;
  logic [DEPTH-1:0]         vld_q;
  logic [DEPTH-1:0][AW-1:0] reg_q;
  logic [DEPTH-1:0][DW-1:0] dat_q;
  logic                     do_push;
  logic                     do_pop;

  // Slot valid bits double as occupancy; wr_ptr==rd_ptr only when all-empty or all-full,
  // so a push and a pop never touch the same slot in one cycle.
  assign full    = &vld_q;
  assign empty   = ~|vld_q;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      vld_q  <= '0;
      reg_q  <= '0;
      dat_q  <= '0;
    end else begin
      if (do_push) begin
        reg_q[wr_ptr] <= push_reg;
        dat_q[wr_ptr] <= push_dat;
        vld_q[wr_ptr] <= 1'b1;
        wr_ptr        <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        vld_q[rd_ptr] <= 1'b0;
        rd_ptr        <= rd_ptr + 1'b1;
      end
    end
  end

  assign head_reg = reg_q[rd_ptr];
  assign head_dat = dat_q[rd_ptr];
  assign ent_vld  = vld_q;
  assign ent_reg  = reg_q;
endmodule

// File: rtl/regfile_write_arbiter.sv
// Round-robin share of the register-file write port between two FIFO'd requesters; RegWrite one cycle after accept.
// Backpressure: reqN_ready = FIFO not full. Define RFARB_STATS_EN to add the conflict_count output.
module regfile_write_arbiter
  import rfarb_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int FIFO_DEPTH = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [ADDR_W-1:0] req0_reg,
  input  logic [DATA_W-1:0] req0_data,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [ADDR_W-1:0] req1_reg,
  input  logic [DATA_W-1:0] req1_data,
  output logic [ADDR_W-1:0] WriteReg,
  output logic [DATA_W-1:0] WriteData,
  output logic              RegWrite,
  input  logic [ADDR_W-1:0] query_reg,
  output logic              query_pending
`ifdef RFARB_STATS_EN
  ,
  output logic [15:0]       conflict_count
`endif
);
  logic                           full0, full1, empty0, empty1;
  logic                           pop0, pop1, both_vld;
  logic [ADDR_W-1:0]              head0_reg, head1_reg, sel_reg;
  logic [DATA_W-1:0]              head0_dat, head1_dat, sel_dat;
  logic [FIFO_DEPTH-1:0]          ent0_vld, ent1_vld;
  logic [FIFO_DEPTH-1:0][ADDR_W-1:0] ent0_reg, ent1_reg;
  logic                           last_grant;
  logic                           hit;

  assign req0_ready = !full0;
  assign req1_ready = !full1;

  rfarb_fifo #(.DEPTH(FIFO_DEPTH), .AW(ADDR_W), .DW(DATA_W)) u_fifo0 (
    .clock    (clock),
    .reset    (reset),
    .push     (req0_valid),
    .push_reg (req0_reg),
    .push_dat (req0_data),
    .pop      (pop0),
    .full     (full0),
    .empty    (empty0),
    .head_reg (head0_reg),
    .head_dat (head0_dat),
    .ent_vld  (ent0_vld),
    .ent_reg  (ent0_reg)
  );

  rfarb_fifo #(.DEPTH(FIFO_DEPTH), .AW(ADDR_W), .DW(DATA_W)) u_fifo1 (
    .clock    (clock),
    .reset    (reset),
    .push     (req1_valid),
    .push_reg (req1_reg),
    .push_dat (req1_data),
    .pop      (pop1),
    .full     (full1),
    .empty    (empty1),
    .head_reg (head1_reg),
    .head_dat (head1_dat),
    .ent_vld  (ent1_vld),
    .ent_reg  (ent1_reg)
  );

  // Round-robin only matters on contention; an uncontested pop leaves last_grant alone.
  assign both_vld = !empty0 && !empty1;
  assign pop0     = !empty0 && (empty1 || (last_grant != GRANT_REQ0));
  assign pop1     = !empty1 && (empty0 || (last_grant != GRANT_REQ1));
  assign sel_reg  = pop0 ? head0_reg : head1_reg;
  assign sel_dat  = pop0 ? head0_dat : head1_dat;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      last_grant <= GRANT_REQ1;
      RegWrite   <= 1'b0;
      WriteReg   <= '0;
      WriteData  <= '0;
    end else begin
      if (both_vld) begin
        last_grant <= pop0 ? GRANT_REQ0 : GRANT_REQ1;
      end
      if (pop0 || pop1) begin
        WriteReg  <= sel_reg;
        WriteData <= sel_dat;
        // x0 entries are consumed but never strobe the register file.
        RegWrite  <= (sel_reg != ADDR_W'(REG_X0));
      end else begin
        RegWrite  <= 1'b0;
      end
    end
  end

  always_comb begin
    hit = 1'b0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if (ent0_vld[i] && (ent0_reg[i] == query_reg)) hit = 1'b1;
      if (ent1_vld[i] && (ent1_reg[i] == query_reg)) hit = 1'b1;
    end
    if (RegWrite && (WriteReg == query_reg)) hit = 1'b1;
    query_pending = hit && (query_reg != ADDR_W'(REG_X0));
  end

`ifdef RFARB_STATS_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      conflict_count <= '0;
    end else if (both_vld && (conflict_count != 16'hFFFF)) begin
      conflict_count <= conflict_count + 16'd1;
    end
  end
`endif
endmodule

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
- Shares the register file's single write port (WriteReg/WriteData/RegWrite) between two writeback requesters, e.g. ALU writeback and load/CSR return.
- Each requester pushes into its own small FIFO with a valid/ready handshake.
- A round-robin arbiter pops one entry per cycle into registered write-port outputs.
- Also gives hazard logic a pending-write query, so a reader can stall while a write to its source register is queued.

Parameters:
- ADDR_W, 6, register index width; matches the register file Read/Write index ports.
- DATA_W, 32, write data width.
- FIFO_DEPTH, 2, entries per requester FIFO; power of two, at least 2.

Ports:
- clock  in  1  single clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- req0_valid  in  1  requester 0 offers a write.
- req0_ready  out  1  requester 0 FIFO not full.
- req0_reg  in  ADDR_W  requester 0 destination register.
- req0_data  in  DATA_W  requester 0 write data.
- req1_valid / req1_ready / req1_reg / req1_data  same as requester 0, for requester 1.
- WriteReg  out  ADDR_W  to register file, registered.
- WriteData  out  DATA_W  to register file, registered.
- RegWrite  out  1  to register file, registered write strobe.
- query_reg  in  ADDR_W  register index under hazard check.
- query_pending  out  1  combinational; a write to query_reg is outstanding.

Behaviour:
- Reset (async):
  - FIFOs are emptied and queued entries discarded.
  - RegWrite=0, WriteReg=0, WriteData=0.
  - last_grant=1, so requester 0 wins the first tie.
  - req*_ready=1 once reset deasserts.
- Accept:
  - An entry is pushed on a rising edge when reqN_valid && reqN_ready.
  - reqN_ready = !fullN, evaluated from state only; no same-cycle pop-through.
  - Requesters must hold valid/reg/data stable until accepted.
- Arbitration, each edge:
  - Only one FIFO non-empty: pop it.
  - Both non-empty: pop the one != last_grant, then update last_grant.
  - Both empty: no pop.
- Output register on a pop:
  - WriteReg/WriteData take the head entry.
  - RegWrite=1 unless head reg==0, in which case RegWrite=0 (writes to x0 are dropped but still consumed).
  - With no pop: RegWrite=0, WriteReg/WriteData hold their previous values.
- Latency:
  - Accept edge E, pop at edge E+1 at the earliest; RegWrite is high during cycle E+1..E+2.
  - Register file commits at edge E+2.
  - Throughput is one write per cycle total.
- Simultaneous push and pop on the same FIFO: both occur; occupancy unchanged.
- Full FIFO: ready=0 and valid is ignored. No entry is ever dropped or duplicated.
- query_pending=1 iff query_reg!=0 and either:
  - any valid FIFO entry in either FIFO matches, or
  - RegWrite=1 and WriteReg==query_reg.
- Ordering: per-requester order is preserved; there is no cross-requester ordering guarantee.
- Reset mid-operation: outputs drop in the same instant; no stale write appears after release.

Optional Feature:
- Macro: RFARB_STATS_EN.
- Defined:
  - Adds output port conflict_count (16 bits).
  - It is a saturating counter of cycles in which both FIFOs are non-empty, cleared by reset, and sticks at 16'hFFFF.
- Undefined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Package rfarb_pkg:
  - default ADDR_W/DATA_W constants;
  - grant encoding constants GRANT_REQ0=0, GRANT_REQ1=1;
  - the x0 index constant.
- Sub-module rfarb_fifo:
  - a synchronous FIFO with push/pop/full/empty, head outputs, and a per-entry valid/reg view for query matching;
  - instantiated twice.

Test Plan:
- Reset, then req0 writes reg 3 = 32'hABCDEFFF for one cycle -> exactly one RegWrite pulse with WriteReg=3 and WriteData=32'hABCDEFFF, one cycle after acceptance; RegWrite otherwise 0.
- Both requesters hold valid with 3 entries each (req0: regs 1,2,3; req1: regs 9,10,11) -> write order 1,9,2,10,3,11 on consecutive cycles; each ready deasserts while its FIFO is full; 6 writes total.
- req0 writes reg 0 = 32'hDEAD -> RegWrite stays 0 throughout; req0_ready returns to 1; query_reg=0 always yields 0.
- req1 queues reg 7 while query_reg=7 -> query_pending=1 from the cycle after accept through the RegWrite cycle, 0 afterwards.
- Both FIFOs full, reset pulsed mid-cycle -> RegWrite falls immediately; after release, no writes occur without new requests.
- With RFARB_STATS_EN: 4 cycles with both FIFOs non-empty -> conflict_count=4.
